// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for the pipelined CPU.
// Turns lb/lbu/lh/lhu/lw/sb/sh/sw into lane-aligned word transactions on a
// req/ack data-memory port, extends load data and stalls the pipeline until
// the access completes or times out (MAX_WAIT cycles in REQ, 0 = no timeout).
// Optional macro MEM_EXC_EN: adds exc_misalign. Misaligned half/word accesses
// skip the bus and finish with an exception pulse.
//
// Handshake: mem_req is held high in REQ with mem_addr/mem_be/mem_we/mem_wdata
// stable. The responder raises mem_ack for one cycle when it accepts a write,
// or when mem_rdata holds the read word. The transfer completes on the rising
// edge where mem_req && mem_ack; mem_req drops on the following cycle.
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_load,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        bus_err,
`ifdef MEM_EXC_EN
  output logic        exc_misalign,
`endif
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [8:0] LP_MAX = 9'(MAX_WAIT);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_addr;
  logic [1:0]  r_addr_lo;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_load;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [7:0]  r_wait;
  logic        r_timeout;
  logic        r_misalign;
  logic [31:0] r_rdata;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misalign;
  logic        w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  // Lane enables and replicated store data for the incoming op.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = op_wdata;
    case (op_size)
      2'b00: begin
        w_be    = 4'b0001 << op_addr[1:0];
        w_wdata = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = op_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{op_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = op_wdata;
      end
    endcase
`ifdef MEM_EXC_EN
    w_misalign = ((op_size == 2'b01) && op_addr[0]) ||
                 (op_size[1] && (op_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
  end

  // Lane extraction and sign/zero extension of the returned read word.
  always_comb begin
    w_byte = mem_rdata[{r_addr_lo, 3'b000} +: 8];
    w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load_val = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_val = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_val = mem_rdata;
    endcase
  end

  // Timeout fires on the REQ cycle that would be the MAX_WAIT-th without ack.
  assign w_timeout = (LP_MAX != 9'd0) && (({1'b0, r_wait} + 9'd1) == LP_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; op_valid in DONE is the same stalled op and is ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (op_valid) w_state_next = w_misalign ? S_DONE : S_REQ;
      S_REQ:  if (mem_ack || w_timeout) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture the op in IDLE, count wait cycles and latch the result in REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= 32'h0;
      r_addr_lo  <= 2'b00;
      r_be       <= 4'h0;
      r_wdata    <= 32'h0;
      r_load     <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_wait     <= 8'h0;
      r_timeout  <= 1'b0;
      r_misalign <= 1'b0;
      r_rdata    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: if (op_valid) begin
          r_addr     <= {op_addr[31:2], 2'b00};
          r_addr_lo  <= op_addr[1:0];
          r_be       <= w_be;
          r_wdata    <= w_wdata;
          r_load     <= op_load;
          r_size     <= op_size;
          r_unsigned <= op_unsigned;
          r_wait     <= 8'h0;
          r_timeout  <= 1'b0;
          r_misalign <= w_misalign;
          if (w_misalign) r_rdata <= 32'h0;
        end
        S_REQ: begin
          if (mem_ack) begin
            r_rdata <= r_load ? w_load_val : 32'h0;
          end else if (w_timeout) begin
            r_rdata   <= 32'h0;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from state and captured registers.
  always_comb begin
    stall       = (r_state == S_REQ) || ((r_state == S_IDLE) && op_valid);
    mem_req     = (r_state == S_REQ);
    mem_we      = (r_state == S_REQ) && !r_load;
    mem_addr    = r_addr;
    mem_be      = r_be;
    mem_wdata   = r_wdata;
    rdata_out   = r_rdata;
    rdata_valid = (r_state == S_DONE);
    bus_err     = (r_state == S_DONE) && r_timeout;
`ifdef MEM_EXC_EN
    exc_misalign = (r_state == S_DONE) && r_misalign;
`endif
    dbg_state   = r_state;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of directed vectors, hand-written reset
// and misalignment sequences, then random ops checked against a lane model.
module tb_mem_access_unit;

  localparam int MAX_WAIT_TB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_load, op_unsigned;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata;
  logic        stall, rdata_valid, bus_err;
  logic [31:0] rdata_out;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  dbg_state;
`ifdef MEM_EXC_EN
  logic        exc_misalign;
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.MAX_WAIT(MAX_WAIT_TB)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_load(op_load), .op_size(op_size),
    .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata),
    .stall(stall), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
    .bus_err(bus_err),
`ifdef MEM_EXC_EN
    .exc_misalign(exc_misalign),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: spec rules in plain arithmetic.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int start_lane(input logic [1:0] sz, input logic [31:0] addr);
    int nb = nbytes(sz);
    return ((int'(addr % 4)) / nb) * nb;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] addr);
    logic [3:0] be;
    int st = start_lane(sz, addr);
    int nb = nbytes(sz);
    for (int i = 0; i < 4; i++) be[i] = (i >= st) && (i < st + nb);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int nb = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] rd);
    longint v;
    int nb = nbytes(sz);
    int st = start_lane(sz, addr);
    v = (longint'(rd) >> (8*st)) & ((64'd1 << (8*nb)) - 1);
    if (!uns && nb < 4 && v >= (64'd1 << (8*nb - 1))) v = v - (64'd1 << (8*nb));
    return v[31:0];
  endfunction

  // Driver + checker for one load/store. Called at posedge+1 in IDLE.
  task automatic run_op(input string tag, input logic ld, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int ack_delay, input logic [31:0] e_addr,
                        input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] e_rdata, input logic e_err);
    int n_req;
    logic [31:0] exp_r;
    n_req = e_err ? MAX_WAIT_TB : ack_delay + 1;
    op_valid = 1'b1; op_load = ld; op_size = sz; op_unsigned = uns;
    op_addr = addr; op_wdata = wdata; mem_ack = 1'b0; mem_rdata = 32'h0;
    exp_q.push_back(e_rdata);
    #1;
    chk({tag, " stall_c0"}, stall, 1'b1);
    chk({tag, " req_c0"}, mem_req, 1'b0);
    next_cycle();
    for (int k = 0; k < n_req; k++) begin
      mem_ack   = (k == ack_delay);
      mem_rdata = (k == ack_delay) ? rdata : $urandom;
      chk({tag, " mem_req"}, mem_req, 1'b1);
      chk({tag, " stall_req"}, stall, 1'b1);
      chk({tag, " valid_req"}, rdata_valid, 1'b0);
      chk({tag, " mem_addr"}, mem_addr, e_addr);
      chk({tag, " mem_be"}, mem_be, e_be);
      chk({tag, " mem_we"}, mem_we, !ld);
      if (!ld) chk({tag, " mem_wdata"}, mem_wdata, e_wdata);
      next_cycle();
    end
    mem_ack = 1'b0;
    exp_r = exp_q.pop_front();
    chk({tag, " rdata_valid"}, rdata_valid, 1'b1);
    chk({tag, " stall_done"}, stall, 1'b0);
    chk({tag, " req_done"}, mem_req, 1'b0);
    chk({tag, " bus_err"}, bus_err, e_err);
    chk({tag, " rdata_out"}, rdata_out, exp_r);
    next_cycle();
    op_valid = 1'b0;
    #1;
    chk({tag, " valid_idle"}, rdata_valid, 1'b0);
    chk({tag, " req_idle"}, mem_req, 1'b0);
    chk({tag, " err_idle"}, bus_err, 1'b0);
  endtask

  typedef struct {
    logic        ld;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_delay;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Reset
    reset = 1'b1; op_valid = 1'b0; op_load = 1'b0; op_size = 2'd0;
    op_unsigned = 1'b0; op_addr = 32'h0; op_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) next_cycle();
    chk("rst stall", stall, 1'b0);
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_be", mem_be, 4'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst rdata_out", rdata_out, 32'h0);
    chk("rst rdata_valid", rdata_valid, 1'b0);
    chk("rst bus_err", bus_err, 1'b0);
    reset = 1'b0;
    next_cycle();

    // Directed vectors
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h1003, 32'h000000AB, 32'h0, 0, 32'h1000, 4'b1000, 32'hABABABAB, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h2001, 32'h0, 32'h1234F678, 3, 32'h2000, 4'b0010, 32'h0, 32'hFFFFFFF6, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 1'b1, 32'h2001, 32'h0, 32'h1234F678, 3, 32'h2000, 4'b0010, 32'h0, 32'h000000F6, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h80010000, 1, 32'h2000, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h80010000, 0, 32'h2000, 4'b1100, 32'h0, 32'h00008001, 1'b0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h00000002, 32'h0000BEEF, 32'h0, 0, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 100, 32'h4000, 4'b1111, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 2, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h3, 32'h0, 32'h80000000, 3, 32'h0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 32'h8, 32'h0, 32'h01234567, 1, 32'h8, 4'b1111, 32'h0, 32'h01234567, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h5, 32'hFFFFFF5A, 32'h0, 2, 32'h4, 4'b0010, 32'h5A5A5A5A, 32'h0, 1'b0});
`ifndef MEM_EXC_EN
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h3002, 32'h0, 32'hCAFEF00D, 0, 32'h3000, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h3003, 32'h0, 32'h9ABC0000, 1, 32'h3000, 4'b1100, 32'h0, 32'hFFFF9ABC, 1'b0});
`endif
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].ld, vecs[i].sz, vecs[i].uns,
             vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].ack_delay,
             vecs[i].e_addr, vecs[i].e_be, vecs[i].e_wdata, vecs[i].e_rdata,
             vecs[i].e_err);

    // Reset on the second REQ cycle
    op_valid = 1'b1; op_load = 1'b1; op_size = 2'd2; op_addr = 32'h20; mem_ack = 1'b0;
    next_cycle();
    chk("mid_rst req1", mem_req, 1'b1);
    next_cycle();
    chk("mid_rst req2", mem_req, 1'b1);
    reset = 1'b1; op_valid = 1'b0;
    next_cycle();
    reset = 1'b0;
    #1;
    chk("mid_rst mem_req", mem_req, 1'b0);
    chk("mid_rst stall", stall, 1'b0);
    chk("mid_rst valid", rdata_valid, 1'b0);
    chk("mid_rst bus_err", bus_err, 1'b0);
    next_cycle();
    chk("mid_rst valid2", rdata_valid, 1'b0);
    chk("mid_rst req2_idle", mem_req, 1'b0);
    run_op("post_rst_sw", 1'b0, 2'd2, 1'b0, 32'h10, 32'h13579BDF, 32'h0, 0,
           32'h10, 4'b1111, 32'h13579BDF, 32'h0, 1'b0);

`ifdef MEM_EXC_EN
    // Misaligned word: no bus cycle, exception pulse one cycle after op_valid
    op_valid = 1'b1; op_load = 1'b1; op_size = 2'd2; op_unsigned = 1'b0; op_addr = 32'h3002;
    #1;
    chk("mis stall_c0", stall, 1'b1);
    next_cycle();
    chk("mis mem_req", mem_req, 1'b0);
    chk("mis exc", exc_misalign, 1'b1);
    chk("mis valid", rdata_valid, 1'b1);
    chk("mis rdata", rdata_out, 32'h0);
    chk("mis stall", stall, 1'b0);
    next_cycle();
    op_valid = 1'b0;
    #1;
    chk("mis exc_idle", exc_misalign, 1'b0);
    chk("mis req_idle", mem_req, 1'b0);
`endif

    // Random ops against the model
    for (int n = 0; n < 60; n++) begin
      logic        ld, uns, err;
      logic [1:0]  sz;
      logic [31:0] addr, wd, rd, er;
      int          dly;
      ld   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      wd   = $urandom;
      rd   = $urandom;
      dly  = $urandom_range(0, 5);
`ifdef MEM_EXC_EN
      addr = addr - (addr % nbytes(sz));
`endif
      err = (dly >= MAX_WAIT_TB);
      er  = (ld && !err) ? m_load(sz, uns, addr, rd) : 32'h0;
      run_op($sformatf("rnd%0d", n), ld, sz, uns, addr, wd, rd, dly,
             addr & 32'hFFFFFFFC, m_be(sz, addr), m_wdata(sz, wd), er, err);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the pipelined CPU. It drives the data-memory responder port (word address, byte enables, write data), and runs a req/ack handshake so memory latency can vary.
- Converts pipeline load/store ops (lb/lbu/lh/lhu/lw/sb/sh/sw) into lane-aligned memory transactions.
- Extracts and sign/zero-extends load data, and stalls the pipeline until the access completes.

Parameters:
- MAX_WAIT, 255, cycles in REQ without mem_ack before the access is aborted with bus_err (8-bit counter; 0 disables the timeout).

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- op_valid  input  1  MEM-stage instruction is a load or store
- op_load  input  1  1 = load, 0 = store
- op_size  input  2  00 byte, 01 halfword, 10 word (11 treated as word)
- op_unsigned  input  1  zero-extend a load (lbu/lhu)
- op_addr  input  32  effective byte address from the ALU
- op_wdata  input  32  store data, right-justified
- stall  output  1  hold IF/ID/EX/MEM stages
- rdata_out  output  32  extended load result, valid while rdata_valid
- rdata_valid  output  1  one-cycle completion pulse (loads and stores)
- bus_err  output  1  one-cycle pulse: access timed out
- mem_req  output  1  memory request
- mem_we  output  1  write strobe, qualified by mem_req
- mem_addr  output  32  {addr[31:2],2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated write data
- mem_ack  input  1  memory accepted the write, or mem_rdata is valid
- mem_rdata  input  32  full read word

Behaviour:
- Reset: state IDLE; wait counter 0; all outputs 0, including mem_* outputs and rdata_out.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - stall = op_valid (combinational).
  - If op_valid: capture op_* into registers and go to REQ.
- REQ:
  - mem_req=1 and stall=1.
  - mem_addr, mem_be, mem_we and mem_wdata come from the captured registers and stay stable until mem_ack.
  - mem_ack is sampled on each rising edge. On ack, load rdata_out (extracted load value, or 0 for a store) and go to DONE.
  - Otherwise increment the wait counter. When it reaches MAX_WAIT (and MAX_WAIT != 0): drop the request, set rdata_out=0, pulse bus_err in DONE.
- DONE:
  - rdata_valid=1 and stall=0; always go to IDLE next cycle.
  - op_valid is ignored here, because the same stalled instruction is still presented this cycle.
- Minimum latency: op_valid at cycle 0 → mem_req at cycle 1 (a zero-wait mem_ack is allowed in that same cycle) → rdata_valid at cycle 2. stall is high in cycles 0–1.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - Loads drive the same mem_be pattern, with mem_we=0.
- Write data: byte is replicated {4{wdata[7:0]}}; half is replicated {2{wdata[15:0]}}; word is passed as-is. This works with responders that select either the lane or the low bytes.
- Load extraction:
  - byte: lane addr[1:0]
  - half: lane addr[1]
  - Sign-extend unless op_unsigned; word loads are passed through.
- Reset mid-operation: go to IDLE immediately at that edge; mem_req drops; no rdata_valid or bus_err pulse is generated.
- The wait counter clears on every entry to REQ.

Optional Feature:
- MEM_EXC_EN defined:
  - Adds output exc_misalign (1 bit).
  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, skips REQ and goes IDLE→DONE.
  - In DONE: exc_misalign=1 for one cycle, rdata_out=0, and no mem_req is issued.
- MEM_EXC_EN undefined:
  - No exc_misalign port.
  - Misaligned low address bits are ignored (half uses addr[1] only; word ignores addr[1:0]) and the access proceeds normally.

Test Plan:
- sb, addr 0x1003, wdata 0x000000AB, mem_ack on the first REQ cycle → mem_be=1000, mem_wdata=0xABABABAB, mem_we=1, mem_addr=0x1000; rdata_valid 2 cycles after op_valid; stall high for exactly 2 cycles.
- lb, addr 0x2001, mem_rdata 0x1234F678, ack after 3 wait cycles → mem_be=0010; rdata_out=0xFFFFFFF6. Same with lbu → 0x000000F6.
- lh, addr 0x2002, mem_rdata 0x8001_0000 → rdata_out=0xFFFF8001; lhu → 0x00008001; sh, wdata 0x0000BEEF, addr 0x2 → mem_be=1100, mem_wdata=0xBEEFBEEF.
- lw with mem_ack never asserted, MAX_WAIT=4 → mem_req high for 4 cycles, then bus_err and rdata_valid pulse together, rdata_out=0, and the FSM returns to IDLE.
- reset asserted on the second REQ cycle → next cycle: mem_req=0, stall=0, no rdata_valid pulse; a following sw to 0x10 completes normally with mem_be=1111.
- With MEM_EXC_EN: lw, addr 0x3002 → no mem_req; exc_misalign and rdata_valid pulse 1 cycle after op_valid. Without MEM_EXC_EN: same op → mem_addr=0x3000, mem_be=1111.
